div_sequencer: RTL and testbench

Multi-cycle signed 64-bit divide unit. It sequences one restoring shift-subtract step per clock over 64 iterations, applies the sign rule, and presents quotient/remainder through a valid/ready handshake. It is the sequential replacement for the combinational divider in the execute stage, giving a short critical path at the cost of 66-cycle latency. Results are bit-identical to the combinational divider, including the divide-by-zero result.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/div_sequencer.sv | 116 +++++++++++
 tb/tb_div_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    localparam int WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Unsigned magnitude of a two's-complement value; the most negative value maps to 2^(N-1).
    function automatic logic [WIDTH_DEF-1:0] abs_mag(input logic [WIDTH_DEF-1:0] v);
        return v[WIDTH_DEF-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {hi, lo} work register.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_hi_sel;
    logic             w_fits;

    assign w_t      = {1'b0, i_hi} - {1'b0, i_divisor};
    assign w_fits   = ~w_t[WIDTH];
    assign w_hi_sel = w_fits ? w_t[WIDTH-1:0] : i_hi;

    // The quotient bit enters at the LSB as the register shifts left.
    assign {o_hi, o_lo} = ({w_hi_sel, i_lo} << 1) | {{(2*WIDTH-1){1'b0}}, w_fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed divider: one restoring step per clock, valid/ready on both sides.
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  ITER  | one shift-subtract step per edge, count runs WIDTH-1 down to 0
//  FIXUP | apply sign / divide-by-zero rule, load result registers
//  DONE  | result held until out_ready
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_work;
    logic [CW-1:0]      r_count;
    logic               r_neg, r_dz;
    logic [WIDTH-1:0]   r_b_mag;
    logic [WIDTH-1:0]   r_quot, r_rem;
    logic               r_dz_out, r_out_valid;

    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_hi_nxt, w_lo_nxt, w_lo;
    logic               w_b_zero;

    // Magnitudes are taken at full package width; WIDTH never exceeds WIDTH_DEF.
    assign w_a_mag  = WIDTH'(abs_mag(WIDTH_DEF'($signed(i_a))));
    assign w_b_mag  = WIDTH'(abs_mag(WIDTH_DEF'($signed(i_b))));
    assign w_b_zero = (i_b == '0);
    assign w_lo     = r_work[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_hi      (r_work[2*WIDTH-1:WIDTH]),
        .i_lo      (w_lo),
        .i_divisor (r_b_mag),
        .o_hi      (w_hi_nxt),
        .o_lo      (w_lo_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_in_valid) w_state_nxt = w_b_zero ? S_FIXUP : S_ITER;
            S_ITER:  if (r_count == '0) w_state_nxt = S_FIXUP;
            S_FIXUP: w_state_nxt = S_DONE;
            S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_work      <= '0;
            r_count     <= '0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_b_mag     <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dz_out    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (i_in_valid) begin
                    r_neg   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                    r_b_mag <= w_b_mag;
                    r_work  <= {{WIDTH{1'b0}}, w_a_mag} << 1;
                    r_count <= CW'(WIDTH-1);
                    r_dz    <= w_b_zero;
                end
                S_ITER: begin
                    r_work  <= {w_hi_nxt, w_lo_nxt};
                    r_count <= r_count - CW'(1);
                end
                S_FIXUP: begin
                    // On divide-by-zero the work register still holds |a| << 1.
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_work[WIDTH:1];
                    end else begin
                        r_quot <= r_neg ? (~w_lo + 1'b1) : w_lo;
                        r_rem  <= {1'b0, r_work[2*WIDTH-1:WIDTH+1]};
                    end
                    r_dz_out    <= r_dz;
                    r_out_valid <= 1'b1;
                end
                S_DONE: if (i_out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_in_ready    = (r_state == S_IDLE);
    assign o_out_valid   = r_out_valid;
    assign o_quotient    = r_quot;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dz_out;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, sign rules, divide-by-zero, back-pressure, reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    div_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_a           (a),
        .i_b           (b),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] av, input logic [63:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = '0;
        b = '0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_div(input string tag, input logic [63:0] av, input logic [63:0] bv,
                           input logic [63:0] eq, input logic [63:0] er, input logic edz,
                           input int elat);
        chk({tag, " in_ready before issue"}, 64'(in_ready), 64'd1);
        issue(av, bv);
        wait_valid(lat);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
        take(tag);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        run_div("pos 100/7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);
        run_div("neg -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 65);
        run_div("neg -100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'd2, 1'b0, 65);
        run_div("dz 100/0", 64'd100, 64'd0, ALL1, 64'd100, 1'b1, 1);
        run_div("dz -7/0", 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ALL1, 64'd7, 1'b1, 1);
        run_div("min/-1", MIN, ALL1, MIN, 64'd0, 1'b0, 65);
        run_div("5/9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65);
        run_div("0/-5", 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 1'b0, 65);
        run_div("min/2", MIN, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 1'b0, 65);

        // in_valid during ITER is ignored
        issue(64'd100, 64'd7);
        repeat (10) step();
        a = 64'd50;
        b = 64'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("iter in_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        wait_valid(lat);
        chk("iter latency", 64'(lat), 64'd50);
        chk("iter quotient", quotient, 64'd14);
        chk("iter remainder", remainder, 64'd2);
        take("iter");
        repeat (3) step();
        chk("iter no second op", 64'(out_valid), 64'd0);

        // Back-pressure: 20 stalled cycles with a competing request on the input
        issue(64'd1000, 64'd3);
        wait_valid(lat);
        chk("bp latency", 64'(lat), 64'd65);
        a = 64'd9;
        b = 64'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp quotient", quotient, 64'd333);
            chk("bp remainder", remainder, 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        take("bp");
        step();
        chk("bp single handshake", 64'(out_valid), 64'd0);
        chk("bp hold after take", quotient, 64'd333);

        // Reset at iteration 30
        issue(64'd100, 64'd7);
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst out_valid", 64'(out_valid), 64'd0);
        chk("mid rst quotient", quotient, 64'd0);
        chk("mid rst remainder", remainder, 64'd0);
        chk("mid rst div_by_zero", 64'(div_by_zero), 64'd0);
        chk("mid rst in_ready", 64'(in_ready), 64'd1);
        repeat (70) step();
        chk("mid rst no stale result", 64'(out_valid), 64'd0);
        run_div("after rst 100/7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
